collision_sequencer: RTL and testbench

COLLISION_SEQUENCER -- requirements
Module: collision_sequencer

---
 rtl/game_pkg.sv | 39 +++
 rtl/corner_gen.sv | 42 ++++
 rtl/collision_sequencer.sv | 140 ++++++++++++++
 tb/tb_collision_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared screen geometry, tile-map constants, corner index
//                encoding and sequencer state encoding for the sprite
//                collision logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Visible screen origin in raw pixel coordinates
    localparam int LEFT       = 143;
    localparam int TOP        = 34;

    // Tile map geometry: 32x32 pixel tiles, 20 columns x 15 rows
    localparam int TILE_SHIFT = 5;
    localparam int COL_MAX    = 19;
    localparam int ROW_MAX    = 14;

    // Coordinate widths: screen address and the carry-extended corner sum
    localparam int COORD_W    = 10;
    localparam int SUM_W      = 11;

    // Corner index encoding: bit0 selects the right edge, bit1 the bottom edge
    localparam logic [1:0] CORNER_TL = 2'd0;
    localparam logic [1:0] CORNER_TR = 2'd1;
    localparam logic [1:0] CORNER_BL = 2'd2;
    localparam logic [1:0] CORNER_BR = 2'd3;
    localparam int CORNER_RIGHT_BIT  = 0;
    localparam int CORNER_BOTTOM_BIT = 1;

    // Sequencer state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PROBE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage : game_pkg
`default_nettype wire

// File: rtl/corner_gen.sv
`default_nettype none
// ============================================================================
//  Module      : corner_gen
//  Description : Combinational corner address generator. Produces the screen
//                coordinate of one bounding-box corner of a sprite at
//                (px_i, py_i) and flags when the 11-bit sum wrapped past the
//                10-bit screen address range.
//  Ports       : px_i, py_i  - sprite top-left corner
//                idx_i       - corner select (TL, TR, BL, BR)
//                cx_o, cy_o  - truncated 10-bit corner coordinate
//                ovf_o       - x or y sum carried into bit 10
//  Revision    : 1.0 - initial release
// ============================================================================
module corner_gen
    import game_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32
) (
    input  logic [COORD_W-1:0] px_i,
    input  logic [COORD_W-1:0] py_i,
    input  logic [1:0]         idx_i,
    output logic [COORD_W-1:0] cx_o,
    output logic [COORD_W-1:0] cy_o,
    output logic               ovf_o
);

    localparam logic [SUM_W-1:0] C_DX = SUM_W'(SPRITE_W - 1);
    localparam logic [SUM_W-1:0] C_DY = SUM_W'(SPRITE_H - 1);

    logic [SUM_W-1:0] w_sum_x;
    logic [SUM_W-1:0] w_sum_y;

    assign w_sum_x = {1'b0, px_i} + (idx_i[CORNER_RIGHT_BIT]  ? C_DX : '0);
    assign w_sum_y = {1'b0, py_i} + (idx_i[CORNER_BOTTOM_BIT] ? C_DY : '0);

    assign cx_o  = w_sum_x[COORD_W-1:0];
    assign cy_o  = w_sum_y[COORD_W-1:0];
    assign ovf_o = w_sum_x[SUM_W-1] | w_sum_y[SUM_W-1];

endmodule : corner_gen
`default_nettype wire

// File: rtl/collision_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : collision_sequencer
//  Description : Probes the four bounding-box corners of a sprite against a
//                single-port tile-map collision bit, one corner per cycle, and
//                reports per-corner solid flags. A corner whose address
//                overflows the screen range is reported as solid.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start, px, py   - probe request and proposed position
//                map_x, map_y    - registered tile-map address
//                map_data        - solid bit for (map_x, map_y), same cycle
//                busy, done      - probe in flight / one-cycle result strobe
//                hit, any_hit    - per-corner flags {BR,BL,TR,TL} and their OR
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_sequencer
    import game_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic [COORD_W-1:0] map_x,
    output logic [COORD_W-1:0] map_y,
    input  logic               map_data,
    output logic               busy,
    output logic               done,
    output logic [3:0]         hit,
    output logic               any_hit
);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] px_q, py_q;
    logic [1:0]         idx_q;
    logic [COORD_W-1:0] map_x_q, map_y_q;
    logic               ovf_q;
    logic [3:0]         hit_q;

    logic               w_accept;
    logic [COORD_W-1:0] w_cg_px, w_cg_py;
    logic [1:0]         w_cg_idx;
    logic [COORD_W-1:0] w_cx, w_cy;
    logic               w_ovf;

    // The DONE->IDLE edge also samples start exactly as IDLE does, so a
    // held start retriggers every five cycles without an idle gap. The
    // done strobe itself is never extended or repeated by start.
    assign w_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // On acceptance the first corner comes straight from the live inputs;
    // afterwards only the latched position is used.
    assign w_cg_px  = w_accept ? px        : px_q;
    assign w_cg_py  = w_accept ? py        : py_q;
    assign w_cg_idx = w_accept ? CORNER_TL : idx_q + 2'd1;

    corner_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_corner_gen (
        .px_i  (w_cg_px),
        .py_i  (w_cg_py),
        .idx_i (w_cg_idx),
        .cx_o  (w_cx),
        .cy_o  (w_cy),
        .ovf_o (w_ovf)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept) state_d = ST_PROBE;
            ST_PROBE: if (idx_q == CORNER_BR) state_d = ST_DONE;
            ST_DONE:  state_d = w_accept ? ST_PROBE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_PROBE: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            px_q    <= '0;
            py_q    <= '0;
            idx_q   <= '0;
            map_x_q <= '0;
            map_y_q <= '0;
            ovf_q   <= 1'b0;
            hit_q   <= '0;
        end else if (w_accept) begin
            px_q    <= px;
            py_q    <= py;
            idx_q   <= CORNER_TL;
            map_x_q <= w_cx;
            map_y_q <= w_cy;
            ovf_q   <= w_ovf;
            hit_q   <= '0;
        end else if (state_q == ST_PROBE) begin
            // map_data belongs to the corner currently on map_x/map_y
            hit_q[idx_q] <= map_data | ovf_q;
            idx_q        <= idx_q + 2'd1;
            if (idx_q != CORNER_BR) begin
                map_x_q <= w_cx;
                map_y_q <= w_cy;
                ovf_q   <= w_ovf;
            end
        end
    end

    assign map_x   = map_x_q;
    assign map_y   = map_y_q;
    assign hit     = hit_q;
    assign any_hit = |hit_q;

endmodule : collision_sequencer
`default_nettype wire

// File: tb/tb_collision_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_sequencer
//  Description : Directed self-checking bench for collision_sequencer with a
//                small tile-map model (empty / single tile (1,1) / all solid).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_sequencer;
    import game_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] px, py;
    logic [9:0] map_x, map_y;
    logic       map_data;
    logic       busy, done;
    logic [3:0] hit;
    logic       any_hit;

    int vectors;
    int miscompares;
    int map_mode;   // 0 empty, 1 tile (row1,col1) solid, 2 all solid

    collision_sequencer #(
        .SPRITE_W (32),
        .SPRITE_H (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .px       (px),
        .py       (py),
        .map_x    (map_x),
        .map_y    (map_y),
        .map_data (map_data),
        .busy     (busy),
        .done     (done),
        .hit      (hit),
        .any_hit  (any_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        map_data = 1'b0;
        if (map_mode == 2) begin
            map_data = 1'b1;
        end else if (map_mode == 1) begin
            if (int'(map_x) >= LEFT && int'(map_y) >= TOP &&
                ((int'(map_x) - LEFT) >> TILE_SHIFT) == 1 &&
                ((int'(map_y) - TOP) >> TILE_SHIFT) == 1)
                map_data = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset state and start coincident with rst
    task automatic test_reset();
        rst = 1'b1; start = 1'b1; px = 10'd175; py = 10'd66;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy, done);
            miscompares++;
        end
        vectors++;
        if (hit !== 4'b0000 || any_hit !== 1'b0) begin
            $display("FAIL reset_hit: hit=%b any_hit=%b expected 0000 0", hit, any_hit);
            miscompares++;
        end
        vectors++;
        if (map_x !== 10'd0 || map_y !== 10'd0) begin
            $display("FAIL reset_map: map=(%0d,%0d) expected (0,0)", map_x, map_y);
            miscompares++;
        end
        start = 1'b0; rst = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_start_ignored: busy=%b expected 0", busy);
            miscompares++;
        end
    endtask

    // Full hit on tile (1,1); address sequence, latching and start-in-PROBE
    task automatic test_tile_hit();
        logic [9:0] ex [4];
        logic [9:0] ey [4];
        ex = '{10'd175, 10'd206, 10'd175, 10'd206};
        ey = '{10'd66,  10'd66,  10'd97,  10'd97};
        map_mode = 1;
        start = 1'b1; px = 10'd175; py = 10'd66;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                start = 1'b0; px = 10'd500; py = 10'd400;
                vectors++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    $display("FAIL tile_busy_e0: busy=%b done=%b expected 1 0", busy, done);
                    miscompares++;
                end
            end
            if (i == 1) start = 1'b1;
            vectors++;
            if (map_x !== ex[i] || map_y !== ey[i]) begin
                $display("FAIL tile_addr_e%0d: map=(%0d,%0d) expected (%0d,%0d)",
                         i, map_x, map_y, ex[i], ey[i]);
                miscompares++;
            end
        end
        tick();
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || hit !== 4'b1111 || any_hit !== 1'b1) begin
            $display("FAIL tile_result: done=%b hit=%b any=%b expected 1 1111 1", done, hit, any_hit);
            miscompares++;
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL tile_e5: done=%b busy=%b expected 0 0", done, busy);
            miscompares++;
        end
        tick(); tick(); tick();
        vectors++;
        if (hit !== 4'b1111 || any_hit !== 1'b1 || map_x !== 10'd206 || map_y !== 10'd97) begin
            $display("FAIL tile_hold: hit=%b any=%b map=(%0d,%0d) expected 1111 1 (206,97)",
                     hit, any_hit, map_x, map_y);
            miscompares++;
        end
    endtask

    // Right corners fall in column 2
    task automatic test_partial();
        map_mode = 1;
        start = 1'b1; px = 10'd191; py = 10'd66;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        vectors++;
        if (done !== 1'b1 || hit !== 4'b0101 || any_hit !== 1'b1) begin
            $display("FAIL partial_result: done=%b hit=%b any=%b expected 1 0101 1", done, hit, any_hit);
            miscompares++;
        end
        tick();
    endtask

    // Coordinate overflow forces hit with an empty map
    task automatic test_overflow();
        map_mode = 0;
        start = 1'b1; px = 10'd1000; py = 10'd100;
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if (map_x !== 10'd7 || map_y !== 10'd100) begin
            $display("FAIL ovf_addr_tr: map=(%0d,%0d) expected (7,100)", map_x, map_y);
            miscompares++;
        end
        tick(); tick(); tick();
        vectors++;
        if (done !== 1'b1 || hit !== 4'b1010 || any_hit !== 1'b1) begin
            $display("FAIL ovf_x_result: done=%b hit=%b any=%b expected 1 1010 1", done, hit, any_hit);
            miscompares++;
        end
        tick();
        start = 1'b1; px = 10'd0; py = 10'd1000;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        vectors++;
        if (done !== 1'b1 || hit !== 4'b1100) begin
            $display("FAIL ovf_y_result: done=%b hit=%b expected 1 1100", done, hit);
            miscompares++;
        end
        tick();
        // Empty map, no overflow: nothing reported
        start = 1'b1; px = 10'd300; py = 10'd200;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        vectors++;
        if (done !== 1'b1 || hit !== 4'b0000 || any_hit !== 1'b0) begin
            $display("FAIL empty_result: done=%b hit=%b any=%b expected 1 0000 0", done, hit, any_hit);
            miscompares++;
        end
        tick();
    endtask

    // Reset in the middle of a probe discards it
    task automatic test_reset_mid();
        bit seen_done;
        bit finished;
        map_mode = 1;
        start = 1'b1; px = 10'd175; py = 10'd66;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hit !== 4'b0000 || any_hit !== 1'b0 || done !== 1'b0) begin
            $display("FAIL rstmid_state: busy=%b hit=%b any=%b done=%b expected 0 0000 0 0",
                     busy, hit, any_hit, done);
            miscompares++;
        end
        vectors++;
        if (map_x !== 10'd0 || map_y !== 10'd0) begin
            $display("FAIL rstmid_map: map=(%0d,%0d) expected (0,0)", map_x, map_y);
            miscompares++;
        end
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        vectors++;
        if (seen_done) begin
            $display("FAIL rstmid_no_done: done=1 expected 0");
            miscompares++;
        end
        start = 1'b1; px = 10'd175; py = 10'd66;
        tick();
        start = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < 10 && !finished; i++) begin
            tick();
            if (done === 1'b1) finished = 1'b1;
        end
        vectors++;
        if (!finished || hit !== 4'b1111) begin
            $display("FAIL rstmid_restart: done_seen=%b hit=%b expected 1 1111", finished, hit);
            miscompares++;
        end
        tick();
    endtask

    // start held high: retrigger every five cycles, py toggled each cycle
    task automatic test_back_to_back();
        logic [3:0] exp_hit [4];
        exp_hit = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
        map_mode = 1;
        start = 1'b1; px = 10'd175; py = 10'd66;
        for (int k = 0; k < 20; k++) begin
            tick();
            py = ((k + 1) % 2 == 0) ? 10'd66 : 10'd34;
            vectors++;
            if (done !== ((k % 5) == 4)) begin
                $display("FAIL b2b_done_e%0d: done=%b expected %b", k, done, (k % 5) == 4);
                miscompares++;
            end
            if ((k % 5) == 4) begin
                vectors++;
                if (hit !== exp_hit[k / 5]) begin
                    $display("FAIL b2b_hit_e%0d: hit=%b expected %b", k, hit, exp_hit[k / 5]);
                    miscompares++;
                end
            end
        end
        start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL b2b_idle: busy=%b expected 0", busy);
            miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        map_mode = 0;
        rst = 1'b1; start = 1'b0; px = '0; py = '0;
        test_reset();
        test_tile_hit();
        test_partial();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule : tb_collision_sequencer
`default_nettype wire
